// File: rtl/tdm_demux41.sv
// -----------------------------------------------------------------------------
// tdm_demux41
//
// Demultiplexes a four-slot time-division frame into four parallel registered
// outputs. A slot is presented on d whenever en is high; sync, sampled together
// with en, marks slot 0 of a frame. Slots 0..2 are collected in shadow
// registers. The slot-3 strobe loads all four outputs in one edge, so a frame
// appears on y0..y3 atomically, together with a one-cycle frame_valid pulse.
//
// Framing FSM:
//   HUNT : waiting for a sync-marked slot; everything else is ignored.
//   RUN  : locked to the frame. A missing sync at slot 0 drops back to HUNT.
//          An early sync (slots 1..3) restarts the frame and stays in RUN.
//          Both cases pulse sync_err.
//
// Handshake: there is no back-pressure. Each cycle with en=1 delivers exactly
// one slot, and d and sync are meaningful only in that cycle. With en=0 the
// block holds all state and the pulse outputs are 0.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   slot strobe
//   d           in   [WIDTH] slot data
//   sync        in   slot-0 marker, qualified by en
//   y0..y3      out  [WIDTH] last complete frame, registered
//   s           out  [2] index of the slot expected on the next en
//   locked      out  1 while the FSM is in RUN
//   frame_valid out  one-cycle pulse when y0..y3 update
//   sync_err    out  one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module tdm_demux41 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [1:0]       s,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] sh [4];

  // Decoded actions for the current cycle.
  logic             cap;        // write d into sh[cap_idx]
  logic [1:0]       cap_idx;
  logic             frame_load; // slot 3 of a good frame: update outputs
  logic             err_d;

  // ---------------------------------------------------------------------------
  // Next-state and action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    cap        = 1'b0;
    cap_idx    = s_q;
    frame_load = 1'b0;
    err_d      = 1'b0;

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            cap     = 1'b1;
            cap_idx = 2'd0;
            s_d     = 2'd1;
            state_d = RUN;
          end
        end

        RUN: begin
          if (sync) begin
            // Sync at slot 0 is a normal frame start; anywhere else it
            // abandons the partial frame but the new slot 0 is still kept.
            err_d   = (s_q != 2'd0);
            cap     = 1'b1;
            cap_idx = 2'd0;
            s_d     = 2'd1;
          end else if (s_q == 2'd0) begin
            // Missing sync: lose lock, discard this slot.
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (s_q == 2'd3) begin
            frame_load = 1'b1;
            cap        = 1'b1;
            s_d        = 2'd0;
          end else begin
            cap = 1'b1;
            s_d = s_q + 2'd1;
          end
        end

        default: begin
          state_d = HUNT;
          s_d     = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, shadow and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      s_q         <= 2'd0;
      for (int i = 0; i < 4; i++) sh[i] <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      if (cap) sh[cap_idx] <= d;
      if (frame_load) begin
        // Slot 3 goes straight from d so the frame lands one clock after
        // its last strobe.
        y0 <= sh[0];
        y1 <= sh[1];
        y2 <= sh[2];
        y3 <= d;
      end
      frame_valid <= frame_load;
      sync_err    <= err_d;
    end
  end

  assign s      = s_q;
  assign locked = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux41.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux41
//
// Directed bench for tdm_demux41 with WIDTH=1. Inputs change on the falling
// edge; outputs are checked 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux41;

  logic       clk;
  logic       rst;
  logic       en;
  logic [0:0] d;
  logic       sync;
  logic [0:0] y0, y1, y2, y3;
  logic [1:0] s;
  logic       locked;
  logic       frame_valid;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  tdm_demux41 #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .d           (d),
    .sync        (sync),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .s           (s),
    .locked      (locked),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and return just after the rising edge.
  task automatic step(input logic e, input logic dv, input logic sv);
    @(negedge clk);
    en   = e;
    d    = dv;
    sync = sv;
    @(posedge clk);
    #1;
  endtask

  // Check everything observable in one go. yv is {y3,y2,y1,y0}.
  task automatic check_all(input string tag, input logic [3:0] yv,
                           input logic [1:0] sv, input logic lk,
                           input logic fv, input logic se);
    check({tag, ".y"},      {28'd0, y3, y2, y1, y0}, {28'd0, yv});
    check({tag, ".s"},      {30'd0, s},              {30'd0, sv});
    check({tag, ".locked"}, {31'd0, locked},         {31'd0, lk});
    check({tag, ".fv"},     {31'd0, frame_valid},    {31'd0, fv});
    check({tag, ".serr"},   {31'd0, sync_err},       {31'd0, se});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    d    = 1'b0;
    sync = 1'b0;

    // Reset state
    #12;
    check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame d=1,0,1,1 -> {y3,y2,y1,y0} = 1101
    step(1'b1, 1'b1, 1'b1);
    check_all("f1.slot0", 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("f1.slot1", 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("f1.slot2", 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("f1.done", 4'b1101, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_all("f1.after", 4'b1101, 2'd0, 1'b1, 1'b0, 1'b0);

    // Frame 0,1,1,0 with three idle cycles after every slot -> 0110
    step(1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b1);
      check_all("gap.s1", 4'b1101, 2'd1, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 1'b0);
      check_all("gap.s2", 4'b1101, 2'd2, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b0);
      check_all("gap.s3", 4'b1101, 2'd3, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    check_all("gap.done", 4'b0110, 2'd0, 1'b1, 1'b1, 1'b0);

    // Early sync at s=2 restarts the frame
    step(1'b1, 1'b1, 1'b1);
    check_all("early.slot0", 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("early.slot1", 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_all("early.err", 4'b0110, 2'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_all("early.r1", 4'b0110, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_all("early.r2", 4'b0110, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    // d0=1 (from the early sync), d1=0, d2=1, d3=0
    check_all("early.done", 4'b0101, 2'd0, 1'b1, 1'b1, 1'b0);

    // Missing sync at s=0 -> lose lock; further unsynced slots ignored
    step(1'b1, 1'b1, 1'b0);
    check_all("miss.err", 4'b0101, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check_all("miss.ign", 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a frame at s=2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check_all("rst.pre", 4'b0101, 2'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all("rst.async", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    // An unsynced slot right after release must be ignored
    step(1'b1, 1'b1, 1'b0);
    check_all("rst.ign", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_all("rst.frame", 4'b0011, 2'd0, 1'b1, 1'b1, 1'b0);

    // Sweep all 16 patterns: n = {d3,d2,d1,d0}
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nv;
      nv = 4'(n);
      step(1'b1, nv[0], 1'b1);
      step(1'b1, nv[1], 1'b0);
      step(1'b1, nv[2], 1'b0);
      step(1'b1, nv[3], 1'b0);
      check({"sweep.y"},  {28'd0, y3, y2, y1, y0}, {28'd0, nv});
      check({"sweep.fv"}, {31'd0, frame_valid},    32'd1);
    end

    step(1'b0, 1'b0, 1'b0);
    check_all("end.idle", 4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdm_demux41.md
TDM_DEMUX41 -- requirements
Module: tdm_demux41

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, meaning the bits carried per time slot.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: slot strobe; d and sync are sampled only when en=1.
REQ-005 The block SHALL have port d, input, WIDTH bits: time-multiplexed data for the current slot.
REQ-006 The block SHALL have port sync, input, 1 bit: asserted with en to mark slot 0 of a frame.
REQ-007 The block SHALL have ports y0, y1, y2 and y3, each an output of WIDTH bits: demultiplexed slot data, registered.
REQ-008 The block SHALL have port s, output, 2 bits: index of the slot expected on the next en.
REQ-009 The block SHALL have port locked, output, 1 bit: 1 while in state RUN.
REQ-010 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when y0..y3 update.
REQ-011 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL implement a two-state FSM, HUNT and RUN, plus a 2-bit slot counter (drives s) and four WIDTH-bit shadow registers sh0..sh3.
REQ-013 The block SHALL hold all state when en=0 (no counter, shadow, FSM or output change); frame_valid and sync_err SHALL be 0 in such cycles.
REQ-014 In HUNT, en=1 with sync=1 SHALL capture d into sh0, set s=1 and move to RUN.
REQ-015 In HUNT, en=1 with sync=0 SHALL be ignored: s stays 0, no pulses.
REQ-016 In RUN, with en=1, sync=0 and s in {1,2}, the block SHALL capture d into sh[s] and increment s.
REQ-017 In RUN, with en=1, sync=0 and s=3, the block SHALL load y0<=sh0, y1<=sh1, y2<=sh2 and y3<=d in the same edge, pulse frame_valid for that cycle, and wrap s to 0; output latency from the slot-3 strobe SHALL be one clock.
REQ-018 In RUN, with en=1, sync=1 and s=0, the block SHALL treat this as a normal frame start: capture sh0 and set s=1.
REQ-019 In RUN, with en=1, sync=0 and s=0 (missing sync), the block SHALL pulse sync_err, discard d, return to HUNT and hold s=0.
REQ-020 In RUN, with en=1, sync=1 and s in {1,2,3} (early sync), the block SHALL pulse sync_err, abandon the partial frame (y unchanged, no frame_valid), capture d into sh0, set s=1 and stay in RUN.
REQ-021 y0..y3 SHALL change only on a frame_valid cycle and SHALL otherwise hold the last complete frame.
REQ-022 frame_valid and sync_err SHALL never be asserted in the same cycle.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL force the FSM to HUNT, s=0, sh0..sh3=0, y0..y3=0, locked=0, frame_valid=0 and sync_err=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL require a new sync before any capture.
REQ-025 The first rising clk edge after rst falls SHALL be processed normally.

Verification
REQ-026 The bench SHALL check this scenario: WIDTH=1; en=1 for four cycles with d=1,0,1,1 and sync on the first only -> next cycle y0..y3=1,0,1,1, frame_valid=1 for one cycle, s=0, locked=1.
REQ-027 The bench SHALL check this scenario: idle gaps (en=0) of 3 cycles between every slot of frame 0,1,1,0 -> same result, with s frozen during the gaps.
REQ-028 The bench SHALL check this scenario: after a locked frame, sync=1 at s=2 -> sync_err pulse, y unchanged, s=1, locked=1; the following 3 slots complete a frame.
REQ-029 The bench SHALL check this scenario: after a completed frame, en=1 at s=0 with sync=0 -> sync_err pulse, locked=0, s=0; subsequent slots without sync are ignored.
REQ-030 The bench SHALL check this scenario: rst pulsed asynchronously between edges while s=2 -> all outputs 0 immediately, locked=0; a new sync-started frame then decodes correctly.
REQ-031 The bench SHALL check this scenario: exhaustive sweep of all 16 slot patterns for WIDTH=1 (counter n applied as {d3,d2,d1,d0}) -> each frame output {y3,y2,y1,y0}=n.
